// File: rtl/vga_pkg.sv
// Shared VGA stream types and constants.
// Sprite geometry, colour type, screen size.
package vga_pkg;

  localparam int SPR_W_LOG2 = 6;
  localparam int SPR_H_LOG2 = 6;
  localparam int SPR_W = 1 << SPR_W_LOG2;
  localparam int SPR_H = 1 << SPR_H_LOG2;

  localparam int HOR_PIXELS = 800;
  localparam int VER_PIXELS = 600;

  typedef logic [11:0] rgb_t;

  localparam rgb_t TRANSPARENT_DEF = 12'hF0F;

  typedef struct packed {
    logic [10:0] vcount;
    logic [10:0] hcount;
    logic        vsync;
    logic        vblnk;
    logic        hsync;
    logic        hblnk;
    rgb_t        rgb;
  } vga_t;

endpackage

// File: rtl/vga_if.sv
// VGA timing + colour bundle.
// Used between pixel pipeline stages.
interface vga_if;

  logic [10:0] vcount;
  logic [10:0] hcount;
  logic        vsync;
  logic        vblnk;
  logic        hsync;
  logic        hblnk;
  logic [11:0] rgb;

  modport in (
    input vcount, hcount, vsync,
    input vblnk, hsync, hblnk, rgb
  );

  modport out (
    output vcount, hcount, vsync,
    output vblnk, hsync, hblnk, rgb
  );

endinterface

// File: rtl/vga_delay.sv
// Fixed-depth delay line for a VGA bundle.
// Zero on reset so outputs never show stale timing.
module vga_delay
  import vga_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  vga_t d,
  output vga_t q
);

  vga_t [DEPTH-1:0] pipe;

  // shift register, stage 0 takes the input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe <= '0;
    end else begin
      pipe[0] <= d;
      for (int i = 1; i < DEPTH; i++)
        pipe[i] <= pipe[i-1];
    end
  end

  assign q = pipe[DEPTH-1];

endmodule

// File: rtl/draw_sprite.sv
// Sprite overlay stage: frame-latched position,
// ROM address gen and 3-cycle composite.
module draw_sprite
  import vga_pkg::*;
#(
  parameter int   SPR_W_LOG2  = 6,
  parameter int   SPR_H_LOG2  = 6,
  parameter rgb_t TRANSPARENT = 12'hF0F
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  output logic [11:0] pixel_addr,
  input  logic [11:0] rgb_pixel,
  vga_if.in           vga_in,
  vga_if.out          vga_out
);

  localparam int AW = SPR_W_LOG2 + SPR_H_LOG2;

  vga_t        s0;
  vga_t        s2;
  logic        fs;
  logic [11:0] x_lat;
  logic [11:0] y_lat;
  logic [11:0] x_eff;
  logic [11:0] y_eff;
  logic [12:0] hx;
  logic [12:0] vy;
  logic [12:0] xl;
  logic [12:0] yl;
  logic        in_box;
  logic        in_box_d1;
  logic        in_box_d2;
  logic [SPR_W_LOG2-1:0] rel_x;
  logic [SPR_H_LOG2-1:0] rel_y;

  assign s0 = '{
    vcount: vga_in.vcount,
    hcount: vga_in.hcount,
    vsync:  vga_in.vsync,
    vblnk:  vga_in.vblnk,
    hsync:  vga_in.hsync,
    hblnk:  vga_in.hblnk,
    rgb:    vga_in.rgb
  };

  assign fs = (vga_in.vcount == 11'd0) &&
              (vga_in.hcount == 11'd0);

  // bypass so the (0,0) pixel already sees the new position
  assign x_eff = fs ? xpos : x_lat;
  assign y_eff = fs ? ypos : y_lat;

  // one spare bit keeps lat+size from wrapping
  assign hx = {2'b00, vga_in.hcount};
  assign vy = {2'b00, vga_in.vcount};
  assign xl = {1'b0, x_eff};
  assign yl = {1'b0, y_eff};

  // hit test against the effective sprite box
  always_comb begin
    in_box = !vga_in.vblnk && !vga_in.hblnk &&
             (hx >= xl) &&
             (hx < xl + 13'(1 << SPR_W_LOG2)) &&
             (vy >= yl) &&
             (vy < yl + 13'(1 << SPR_H_LOG2));
  end

  assign rel_x = vga_in.hcount[SPR_W_LOG2-1:0] -
                 x_eff[SPR_W_LOG2-1:0];
  assign rel_y = vga_in.vcount[SPR_H_LOG2-1:0] -
                 y_eff[SPR_H_LOG2-1:0];

  // position is sampled only at frame start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_lat <= '0;
      y_lat <= '0;
    end else if (fs) begin
      x_lat <= xpos;
      y_lat <= ypos;
    end
  end

  // ROM address and hit flag pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_addr <= '0;
      in_box_d1  <= 1'b0;
      in_box_d2  <= 1'b0;
    end else begin
      pixel_addr <= in_box ? 12'(AW'({rel_y, rel_x})) : '0;
      in_box_d1  <= in_box;
      in_box_d2  <= in_box_d1;
    end
  end

  vga_delay #(
    .DEPTH (2)
  ) u_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (s0),
    .q     (s2)
  );

  // output register with sprite/background mux
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_out.vcount <= '0;
      vga_out.hcount <= '0;
      vga_out.vsync  <= 1'b0;
      vga_out.vblnk  <= 1'b0;
      vga_out.hsync  <= 1'b0;
      vga_out.hblnk  <= 1'b0;
      vga_out.rgb    <= '0;
    end else begin
      vga_out.vcount <= s2.vcount;
      vga_out.hcount <= s2.hcount;
      vga_out.vsync  <= s2.vsync;
      vga_out.vblnk  <= s2.vblnk;
      vga_out.hsync  <= s2.hsync;
      vga_out.hblnk  <= s2.hblnk;
      vga_out.rgb    <=
        (in_box_d2 && rgb_pixel != TRANSPARENT) ?
        rgb_pixel : s2.rgb;
    end
  end

endmodule
